// File: rtl/msk_pkg.sv
// Shared types and defaults for the MSK bit decider back-end.
package msk_pkg;

  typedef enum logic {
    BR_I = 1'b0,
    BR_Q = 1'b1
  } branch_e;

  localparam int DEF_SPB      = 32;
  localparam int DEF_TOL      = 2;
  localparam int DEF_LOCK_CNT = 16;
  localparam int SOFT_W       = 8;

endpackage

// File: rtl/msk_lock_det.sv
// Strobe timing supervisor: interval measurement, good-interval counting,
// timeout detection and the locked flag.
module msk_lock_det
  import msk_pkg::*;
#(
  parameter int SPB      = DEF_SPB,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_strobe,
  output logic o_locked,
  output logic o_timing_err
);

  localparam int CW = $clog2(2 * SPB + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(2 * SPB);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] WIN_LO   = CW'(SPB - TOL);
  localparam logic [CW-1:0] WIN_HI   = CW'(SPB + TOL);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);
  localparam logic [GW-1:0] GOOD_ONE = GW'(1);

  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [GW-1:0] r_good, w_good_nxt;
  logic          r_started, w_started_nxt;
  logic          r_to_done, w_to_done_nxt;
  logic          w_in_win;
  logic          w_err;

  // The first strobe after reset only arms the counter; timeout fires once per gap.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_good_nxt    = r_good;
    w_started_nxt = r_started;
    w_to_done_nxt = r_to_done;
    w_err         = 1'b0;
    w_in_win      = (r_cnt >= WIN_LO) && (r_cnt <= WIN_HI);
    if (i_strobe) begin
      w_cnt_nxt     = CNT_ONE;
      w_started_nxt = 1'b1;
      w_to_done_nxt = 1'b0;
      if (!r_started) begin
        w_good_nxt = r_good;
      end else if (w_in_win) begin
        w_good_nxt = (r_good == GOOD_MAX) ? r_good : r_good + GOOD_ONE;
      end else begin
        w_good_nxt = '0;
        w_err      = 1'b1;
      end
    end else if (r_cnt != CNT_MAX) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end else if (r_started && !r_to_done) begin
      w_good_nxt    = '0;
      w_to_done_nxt = 1'b1;
      w_err         = 1'b1;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  assign o_timing_err = w_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_good    <= '0;
      r_started <= 1'b0;
      r_to_done <= 1'b0;
      o_locked  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_good    <= w_good_nxt;
      r_started <= w_started_nxt;
      r_to_done <= w_to_done_nxt;
      o_locked  <= (w_good_nxt == GOOD_MAX);
    end
  end

endmodule

// File: rtl/msk_bit_decider.sv
// MSK demodulator back-end: hard decisions, differential decode, bit clock, lock.
// Optional soft-decision output enabled by defining MSK_SOFT_OUT_EN.
module msk_bit_decider
  import msk_pkg::*;
#(
  parameter int DW       = 26,
  parameter int SPB      = DEF_SPB,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int DIFF_DEC = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] it,
  input  logic signed [DW-1:0] qt,
  input  logic                 isync,
  input  logic                 qsync,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 bit_sync,
  output logic                 locked,
  output logic                 sync_err
`ifdef MSK_SOFT_OUT_EN
  ,
  output logic signed [SOFT_W-1:0] soft_out
`endif
);

  localparam int HALF = SPB / 2;
  localparam int BW   = $clog2(HALF + 1);
  localparam logic signed [DW-1:0] ZERO = '0;
  localparam logic [BW-1:0] BS_LOAD = BW'(HALF - 1);
  localparam logic [BW-1:0] BS_ONE  = BW'(1);

  logic                 w_strobe;
  logic                 w_dual;
  logic                 w_branch_err;
  logic                 w_timing_err;
  logic                 w_dec;
  branch_e              w_branch;
  branch_e              r_last_branch;
  logic signed [DW-1:0] w_sample;
  logic                 r_s1_valid;
  logic                 r_raw;
  logic                 r_prev;
  logic [BW-1:0]        r_bs_cnt;

  // I wins when both strobes coincide; Q is dropped and flagged.
  always_comb begin
    w_strobe = isync | qsync;
    w_dual   = isync & qsync;
    if (isync) begin
      w_branch = BR_I;
      w_sample = it;
    end else begin
      w_branch = BR_Q;
      w_sample = qt;
    end
    w_branch_err = w_strobe & (w_dual | (w_branch == r_last_branch));
    w_dec        = (DIFF_DEC != 0) ? (r_raw ^ r_prev) : r_raw;
  end

  msk_lock_det #(
    .SPB      (SPB),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT)
  ) u_lock_det (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_strobe     (w_strobe),
    .o_locked     (locked),
    .o_timing_err (w_timing_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid    <= 1'b0;
      r_raw         <= 1'b0;
      r_last_branch <= BR_Q;
      sync_err      <= 1'b0;
    end else begin
      r_s1_valid <= w_strobe;
      sync_err   <= w_branch_err | w_timing_err;
      if (w_strobe) begin
        r_raw         <= (w_sample >= ZERO);
        r_last_branch <= w_branch;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      r_prev     <= 1'b0;
    end else begin
      dout_valid <= r_s1_valid;
      if (r_s1_valid) begin
        dout   <= w_dec;
        r_prev <= r_raw;
      end
    end
  end

  // Bit clock: high for HALF cycles from each dout_valid, restarted by a new one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_sync <= 1'b0;
      r_bs_cnt <= '0;
    end else if (r_s1_valid) begin
      bit_sync <= 1'b1;
      r_bs_cnt <= BS_LOAD;
    end else if (r_bs_cnt != '0) begin
      bit_sync <= 1'b1;
      r_bs_cnt <= r_bs_cnt - BS_ONE;
    end else begin
      bit_sync <= 1'b0;
    end
  end

`ifdef MSK_SOFT_OUT_EN
  logic signed [SOFT_W-1:0] r_soft;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_soft   <= '0;
      soft_out <= '0;
    end else begin
      if (w_strobe) begin
        r_soft <= w_sample[DW-1 -: SOFT_W];
      end
      if (r_s1_valid) begin
        soft_out <= r_soft;
      end
    end
  end
`endif

endmodule

// File: tb/tb_msk_bit_decider.sv
// Randomized bench for msk_bit_decider; one instance with and one without
// differential decoding, both compared every cycle against an event-level model.
module tb_msk_bit_decider;
  import msk_pkg::*;

  localparam int DW       = 26;
  localparam int SPB      = 32;
  localparam int TOL      = 2;
  localparam int LOCK_CNT = 16;
  localparam int HALF     = SPB / 2;
  localparam int MAXC     = 8192;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b1;
  logic signed [DW-1:0] it = '0;
  logic signed [DW-1:0] qt = '0;
  logic                 isync = 1'b0;
  logic                 qsync = 1'b0;
  logic d1_dout, d1_valid, d1_bs, d1_lock, d1_err;
  logic d0_dout, d0_valid, d0_bs, d0_lock, d0_err;
`ifdef MSK_SOFT_OUT_EN
  logic signed [7:0] d1_soft, d0_soft;
`endif

  always #5 clk = ~clk;

  msk_bit_decider #(.DW(DW), .SPB(SPB), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .DIFF_DEC(1)) dut (
    .clk(clk), .reset_n(reset_n), .it(it), .qt(qt), .isync(isync), .qsync(qsync),
    .dout(d1_dout), .dout_valid(d1_valid), .bit_sync(d1_bs), .locked(d1_lock), .sync_err(d1_err)
`ifdef MSK_SOFT_OUT_EN
    , .soft_out(d1_soft)
`endif
  );

  msk_bit_decider #(.DW(DW), .SPB(SPB), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .DIFF_DEC(0)) dut_raw (
    .clk(clk), .reset_n(reset_n), .it(it), .qt(qt), .isync(isync), .qsync(qsync),
    .dout(d0_dout), .dout_valid(d0_valid), .bit_sync(d0_bs), .locked(d0_lock), .sync_err(d0_err)
`ifdef MSK_SOFT_OUT_EN
    , .soft_out(d0_soft)
`endif
  );

  // Expected outputs per absolute cycle number.
  bit exp_valid [MAXC];
  bit exp_d1    [MAXC];
  bit exp_d0    [MAXC];
  bit exp_err   [MAXC];
  bit exp_lock  [MAXC];
  logic signed [7:0] exp_soft [MAXC];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int   last_strobe = 0;
  int   good = 0;
  int   last_v = -1;
  int   last_br = 1;
  bit   started = 1'b0;
  bit   prev = 1'b0;
  bit   cur1 = 1'b0;
  bit   cur0 = 1'b0;
  logic signed [7:0] cur_soft = '0;
  bit   use_i = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] rand_val();
    logic signed [DW-1:0] v;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = {1'b0, {(DW-1){1'b1}}};
      3: v = {1'b1, {(DW-1){1'b0}}};
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  // Apply the rules to the inputs of cycle cyc; fill in expectations for later cycles.
  task automatic model_step();
    bit raw;
    bit err;
    int br;
    int dev;
    logic signed [DW-1:0] s;
    if (!reset_n) begin
      started = 1'b0; last_br = 1; prev = 1'b0; good = 0;
      last_v = -1; cur1 = 1'b0; cur0 = 1'b0; cur_soft = '0;
      exp_valid[cyc+1] = 1'b0; exp_valid[cyc+2] = 1'b0;
      exp_err[cyc+1] = 1'b0; exp_lock[cyc+1] = 1'b0;
      return;
    end
    err = 1'b0;
    if (isync || qsync) begin
      br  = isync ? 0 : 1;
      s   = isync ? it : qt;
      raw = (s >= 0);
      if (isync && qsync) err = 1'b1;
      if (br == last_br) err = 1'b1;
      last_br = br;
      if (started) begin
        dev = cyc - last_strobe - SPB;
        if (dev < 0) dev = -dev;
        if (dev <= TOL) begin
          if (good < LOCK_CNT) good = good + 1;
        end else begin
          good = 0;
          err = 1'b1;
        end
      end
      started = 1'b1;
      last_strobe = cyc;
      exp_valid[cyc+2] = 1'b1;
      exp_d1[cyc+2]    = raw ^ prev;
      exp_d0[cyc+2]    = raw;
      exp_soft[cyc+2]  = 8'(s >>> (DW - 8));
      prev = raw;
    end else if (started && (cyc - last_strobe) == 2 * SPB) begin
      good = 0;
      err = 1'b1;
    end
    exp_err[cyc+1]  = err;
    exp_lock[cyc+1] = (good == LOCK_CNT);
  endtask

  task automatic compare();
    bit bs;
    if (exp_valid[cyc]) begin
      last_v = cyc; cur1 = exp_d1[cyc]; cur0 = exp_d0[cyc]; cur_soft = exp_soft[cyc];
    end
    bs = (last_v >= 0) && (cyc - last_v < HALF);
    check_eq("dout_valid", d1_valid, exp_valid[cyc]);
    check_eq("dout_valid_raw", d0_valid, exp_valid[cyc]);
    check_eq("dout_diff", d1_dout, cur1);
    check_eq("dout_raw", d0_dout, cur0);
    check_eq("bit_sync", d1_bs, bs);
    check_eq("bit_sync_raw", d0_bs, bs);
    check_eq("locked", d1_lock, exp_lock[cyc]);
    check_eq("locked_raw", d0_lock, exp_lock[cyc]);
    check_eq("sync_err", d1_err, exp_err[cyc]);
    check_eq("sync_err_raw", d0_err, exp_err[cyc]);
`ifdef MSK_SOFT_OUT_EN
    check_eq("soft_out", d1_soft, cur_soft);
    check_eq("soft_out_raw", d0_soft, cur_soft);
`endif
  endtask

  task automatic run_cycle(input bit is, input bit qs,
                           input logic signed [DW-1:0] iv, input logic signed [DW-1:0] qv);
    isync = is; qsync = qs; it = iv; qt = qv;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(1'b0, 1'b0, rand_val(), rand_val());
  endtask

  task automatic strobe_at(input int gap, input bit is, input bit qs,
                           input logic signed [DW-1:0] iv, input logic signed [DW-1:0] qv);
    if (gap > 1) idle(gap - 1);
    run_cycle(is, qs, iv, qv);
  endtask

  task automatic async_reset(input int hold);
    reset_n = 1'b0;
    #1;
    check_eq("rst_dout", d1_dout, 1'b0);
    check_eq("rst_valid", d1_valid, 1'b0);
    check_eq("rst_bit_sync", d1_bs, 1'b0);
    check_eq("rst_locked", d1_lock, 1'b0);
    check_eq("rst_sync_err", d1_err, 1'b0);
    repeat (hold) run_cycle(1'($urandom), 1'($urandom), rand_val(), rand_val());
    reset_n = 1'b1;
  endtask

  initial begin
    int sel;
    int gap;
    bit is;
    bit qs;
    #2;
    async_reset(8);
    idle(5);
    // Alternating I/Q at nominal rate: locks after the 17th strobe
    for (int i = 0; i < 20; i++) begin
      strobe_at((i == 0) ? 3 : SPB, (i % 2) == 0, (i % 2) == 1, 26'sd1000, -26'sd1000);
    end
    strobe_at(30, 1'b0, 1'b1, rand_val(), rand_val());
    strobe_at(34, 1'b1, 1'b0, 26'h0ABCDEF, rand_val());
    strobe_at(31, 1'b0, 1'b1, rand_val(), rand_val());
    strobe_at(40, 1'b1, 1'b0, rand_val(), rand_val());
    strobe_at(SPB, 1'b1, 1'b1, -26'sd5, 26'sd7);
    strobe_at(SPB, 1'b1, 1'b0, 26'sd0, rand_val());
    strobe_at(SPB, 1'b1, 1'b0, -26'sd1, rand_val());
    idle(100);
    strobe_at(SPB, 1'b0, 1'b1, rand_val(), rand_val());
    idle(7);
    async_reset(3);
    idle(2);
    strobe_at(SPB, 1'b1, 1'b0, 26'sd1000, rand_val());
    strobe_at(SPB, 1'b0, 1'b1, rand_val(), 26'sd500);
    strobe_at(SPB, 1'b1, 1'b0, -26'sd3, rand_val());
    strobe_at(SPB, 1'b0, 1'b1, rand_val(), 26'sd0);
    use_i = 1'b0;
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) gap = $urandom_range(1, 75);
      else gap = $urandom_range(SPB - TOL - 1, SPB + TOL + 1);
      if (sel == 0) begin
        is = 1'b1; qs = 1'b1;
      end else if (sel == 1) begin
        is = use_i; qs = !use_i;
      end else begin
        use_i = !use_i; is = use_i; qs = !use_i;
      end
      strobe_at(gap, is, qs, rand_val(), rand_val());
    end
    idle(80);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
